// File: rtl/rew_cmd_issuer.sv
// REW command issuer: takes one path base address per REW phase and issues
// that phase's chunk commands to DRAM, pulsing the matching status-counter transfer strobe.
module rew_cmd_issuer #(
  parameter int AW         = 30,
  parameter int BStride    = 8,
  parameter int RW_R_Chunk = 0,
  parameter int RW_W_Chunk = 0,
  parameter int RO_R_Chunk = 0,
  parameter int RO_W_Chunk = 0
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          RWAccess,
  input  logic          ROAccess,
  input  logic          Read,
  input  logic          Writeback,
  input  logic [AW-1:0] PathAddr,
  input  logic          PathAddrValid,
  output logic          PathAddrReady,
  output logic          RW_R_Transfer,
  output logic          RW_W_Transfer,
  output logic          RO_R_Transfer,
  output logic          RO_W_Transfer,
  output logic [AW-1:0] DRAMCommandAddress,
  output logic [2:0]    DRAMCommand,
  output logic          DRAMCommandValid,
  input  logic          DRAMCommandReady
);

  localparam int MaxRw    = (RW_R_Chunk > RW_W_Chunk) ? RW_R_Chunk : RW_W_Chunk;
  localparam int MaxRo    = (RO_R_Chunk > RO_W_Chunk) ? RO_R_Chunk : RO_W_Chunk;
  localparam int MaxChunk = (MaxRw > MaxRo) ? MaxRw : MaxRo;
  localparam int IW       = (MaxChunk < 1) ? 1 : $clog2(MaxChunk + 1);

  localparam logic [2:0] CmdRead  = 3'b001;
  localparam logic [2:0] CmdWrite = 3'b000;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e          state_q, state_d;
  logic [3:0]      phase_q, phase_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   limit_q, limit_d;
  logic            valid_q, valid_d;
  logic [2:0]      cmd_q, cmd_d;

  logic [3:0]      phaseNow;
  logic            phaseValid;
  logic            addrHs;
  logic            cmdHs;
  logic [IW-1:0]   chunksNow;
  logic [AW-1:0]   nextAddr;

  // Phase tuple packs {RWAccess, ROAccess, Read, Writeback}.
  assign phaseNow   = {RWAccess, ROAccess, Read, Writeback};
  assign phaseValid = (RWAccess ^ ROAccess) && (Read ^ Writeback);

  assign PathAddrReady = Reset_n && (state_q == StIdle) && phaseValid;
  assign addrHs        = PathAddrValid && PathAddrReady;
  assign cmdHs         = valid_q && DRAMCommandReady;

  assign nextAddr = base_q + AW'(idx_q + IW'(1)) * AW'(BStride);

  assign DRAMCommandAddress = addr_q;
  assign DRAMCommand        = cmd_q;
  assign DRAMCommandValid   = valid_q;

  // Strobes follow the latched phase, which is one-hot per axis once accepted.
  assign RW_R_Transfer = cmdHs && phase_q[3] && phase_q[1];
  assign RW_W_Transfer = cmdHs && phase_q[3] && phase_q[0];
  assign RO_R_Transfer = cmdHs && phase_q[2] && phase_q[1];
  assign RO_W_Transfer = cmdHs && phase_q[2] && phase_q[0];

  always_comb begin
    chunksNow = '0;
    if (RWAccess && Read)           chunksNow = IW'(RW_R_Chunk);
    else if (RWAccess && Writeback) chunksNow = IW'(RW_W_Chunk);
    else if (ROAccess && Read)      chunksNow = IW'(RO_R_Chunk);
    else if (ROAccess && Writeback) chunksNow = IW'(RO_W_Chunk);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    limit_d = limit_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      StIdle: begin
        if (addrHs) begin
          phase_d = phaseNow;
          base_d  = PathAddr;
          idx_d   = '0;
          limit_d = chunksNow;
          if (chunksNow != '0) begin
            state_d = StIssue;
            valid_d = 1'b1;
            addr_d  = PathAddr;
            cmd_d   = Read ? CmdRead : CmdWrite;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StIssue: begin
        if (cmdHs) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == limit_q - IW'(1)) begin
            state_d = StDrain;
            valid_d = 1'b0;
          end else begin
            addr_d = nextAddr;
          end
        end
      end
      StDrain: begin
        if (phaseNow != phase_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      limit_q <= '0;
      valid_q <= 1'b0;
      cmd_q   <= CmdRead;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      limit_q <= limit_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
    end
  end

endmodule

// File: tb/tb_rew_cmd_issuer.sv
// Bench for rew_cmd_issuer: a queue-based model of expected commands is compared
// against the DUT every cycle, plus literal expectations for each directed scenario.
module tb_rew_cmd_issuer;

  localparam int AW = 32;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          RWAccess, ROAccess, Read, Writeback;
  logic [AW-1:0] PathAddr;
  logic          PathAddrValid;
  logic          PathAddrReady;
  logic          RW_R_Transfer, RW_W_Transfer, RO_R_Transfer, RO_W_Transfer;
  logic [AW-1:0] DRAMCommandAddress;
  logic [2:0]    DRAMCommand;
  logic          DRAMCommandValid;
  logic          DRAMCommandReady;

  always #5 Clock = ~Clock;

  rew_cmd_issuer #(
    .AW(AW), .BStride(8),
    .RW_R_Chunk(4), .RW_W_Chunk(4), .RO_R_Chunk(3), .RO_W_Chunk(0)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .RWAccess(RWAccess), .ROAccess(ROAccess), .Read(Read), .Writeback(Writeback),
    .PathAddr(PathAddr), .PathAddrValid(PathAddrValid), .PathAddrReady(PathAddrReady),
    .RW_R_Transfer(RW_R_Transfer), .RW_W_Transfer(RW_W_Transfer),
    .RO_R_Transfer(RO_R_Transfer), .RO_W_Transfer(RO_W_Transfer),
    .DRAMCommandAddress(DRAMCommandAddress), .DRAMCommand(DRAMCommand),
    .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: a pending-command list per accepted path plus a busy flag.
  bit            busy = 1'b0;
  logic [3:0]    latched = '0;
  logic [2:0]    expCmd = 3'b001;
  logic [AW-1:0] expQ[$];
  logic [AW-1:0] accLog[$];
  logic [2:0]    cmdLog[$];
  logic [3:0]    phaseNow, expXfer, gotXfer;
  logic          expReady, expValid, fire;

  function automatic int chunksFor(input logic [3:0] p);
    if (p[3] && p[1]) return 4;
    if (p[3] && p[0]) return 4;
    if (p[2] && p[1]) return 3;
    return 0;
  endfunction

  function automatic logic phaseOk(input logic [3:0] p);
    return (p[3] ^ p[2]) && (p[1] ^ p[0]);
  endfunction

  always @(negedge Clock) begin
    phaseNow = {RWAccess, ROAccess, Read, Writeback};
    if (!Reset_n) begin
      busy = 1'b0;
      expQ.delete();
    end
    expReady = Reset_n && !busy && phaseOk(phaseNow);
    expValid = busy && (expQ.size() != 0);
    fire     = expValid && DRAMCommandReady;
    checkOutput("PathAddrReady", PathAddrReady, expReady);
    checkOutput("CmdValid", DRAMCommandValid, expValid);
    if (expValid) begin
      checkOutput("CmdAddr", DRAMCommandAddress, expQ[0]);
      checkOutput("CmdOp", DRAMCommand, expCmd);
    end
    if (!Reset_n) begin
      checkOutput("RstAddr", DRAMCommandAddress, 0);
      checkOutput("RstOp", DRAMCommand, 3'b001);
    end
    expXfer = fire ? {latched[3] & latched[1], latched[3] & latched[0],
                      latched[2] & latched[1], latched[2] & latched[0]} : 4'b0000;
    gotXfer = {RW_R_Transfer, RW_W_Transfer, RO_R_Transfer, RO_W_Transfer};
    checkOutput("Transfer", gotXfer, expXfer);
    if (Reset_n) begin
      if (fire) begin
        accLog.push_back(expQ.pop_front());
        cmdLog.push_back(expCmd);
      end else if (busy && expQ.size() == 0 && phaseNow != latched) begin
        busy = 1'b0;
      end
      if (PathAddrValid && expReady) begin
        busy    = 1'b1;
        latched = phaseNow;
        expCmd  = Read ? 3'b001 : 3'b000;
        for (int i = 0; i < chunksFor(phaseNow); i++)
          expQ.push_back(PathAddr + AW'(i * 8));
      end
    end
  end

  // Observed DUT activity, used for loop bounds and literal pulse counts.
  int dutAccepted = 0;
  int dutPulses[4];
  int cycle = 0;
  int acceptCycle[$];

  always @(posedge Clock) begin
    cycle++;
    if (DRAMCommandValid && DRAMCommandReady) begin
      dutAccepted++;
      acceptCycle.push_back(cycle);
    end
    if (RW_R_Transfer) dutPulses[0]++;
    if (RW_W_Transfer) dutPulses[1]++;
    if (RO_R_Transfer) dutPulses[2]++;
    if (RO_W_Transfer) dutPulses[3]++;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic ro, input logic rd, input logic wb,
                               input logic [AW-1:0] addr, input logic av);
    RWAccess      = rw;
    ROAccess      = ro;
    Read          = rd;
    Writeback     = wb;
    PathAddr      = addr;
    PathAddrValid = av;
  endtask

  task automatic clearLogs();
    accLog.delete();
    cmdLog.delete();
    acceptCycle.delete();
    dutAccepted = 0;
    for (int i = 0; i < 4; i++) dutPulses[i] = 0;
  endtask

  task automatic waitDone(input string name, input int n, input bit toggle);
    for (int i = 0; i < 60; i++) begin
      if (dutAccepted >= n && !DRAMCommandValid) break;
      tick();
      if (toggle) DRAMCommandReady = ~DRAMCommandReady;
    end
    checkOutput(name, dutAccepted, n);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    DRAMCommandReady = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) tick();
    checkOutput("rstValid", DRAMCommandValid, 0);
    checkOutput("rstReady", PathAddrReady, 0);
    Reset_n = 1'b1;
    tick();

    $display("[TB] RW read burst, ready held high");
    clearLogs();
    DRAMCommandReady = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1);
    tick();
    PathAddrValid = 1'b0;
    waitDone("rwReadCount", 4, 1'b0);
    checkOutput("rwReadLogSize", accLog.size(), 4);
    if (accLog.size() == 4) begin
      checkOutput("rwReadA0", accLog[0], 32'h100);
      checkOutput("rwReadA1", accLog[1], 32'h108);
      checkOutput("rwReadA2", accLog[2], 32'h110);
      checkOutput("rwReadA3", accLog[3], 32'h118);
    end
    checkOutput("rwReadPulses", dutPulses[0], 4);
    if (acceptCycle.size() == 4)
      checkOutput("rwReadBackToBack", acceptCycle[3] - acceptCycle[0], 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) tick();

    $display("[TB] RO read burst, ready toggling");
    clearLogs();
    DRAMCommandReady = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 1'b1);
    tick();
    PathAddrValid = 1'b0;
    waitDone("roReadCount", 3, 1'b1);
    checkOutput("roReadPulses", dutPulses[2], 3);
    checkOutput("roReadOtherPulses", dutPulses[0] + dutPulses[1] + dutPulses[3], 0);
    if (accLog.size() == 3) checkOutput("roReadLast", accLog[2], 32'h2010);
    DRAMCommandReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) tick();

    $display("[TB] RO writeback, zero chunks");
    clearLogs();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
    tick();
    PathAddrValid = 1'b0;
    repeat (5) tick();
    checkOutput("roWbDrainReady", PathAddrReady, 0);
    checkOutput("roWbCommands", dutAccepted, 0);
    checkOutput("roWbPulses", dutPulses[3], 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0);
    tick();
    checkOutput("drainExitReady", PathAddrReady, 1);

    $display("[TB] RW write burst wrapping the address space");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    tick();
    PathAddrValid = 1'b0;
    waitDone("rwWriteCount", 4, 1'b0);
    if (accLog.size() == 4) begin
      checkOutput("wrapA0", accLog[0], 32'hFFFF_FFF8);
      checkOutput("wrapA1", accLog[1], 32'h0);
      checkOutput("wrapA2", accLog[2], 32'h8);
      checkOutput("wrapA3", accLog[3], 32'h10);
      checkOutput("wrapOp", cmdLog[3], 3'b000);
    end
    checkOutput("rwWritePulses", dutPulses[1], 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) tick();

    $display("[TB] reset in the middle of a burst");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 1'b1);
    tick();
    PathAddrValid = 1'b0;
    for (int i = 0; i < 20 && dutAccepted < 2; i++) tick();
    Reset_n = 1'b0;
    #1;
    checkOutput("midRstAccepted", dutAccepted, 2);
    checkOutput("midRstValid", DRAMCommandValid, 0);
    checkOutput("midRstAddr", DRAMCommandAddress, 0);
    checkOutput("midRstOp", DRAMCommand, 3'b001);
    checkOutput("midRstReady", PathAddrReady, 0);
    checkOutput("midRstXfer", {RW_R_Transfer, RW_W_Transfer, RO_R_Transfer, RO_W_Transfer}, 0);
    repeat (2) tick();
    Reset_n = 1'b1;
    #1;
    checkOutput("postRstReady", PathAddrReady, 1);
    repeat (4) tick();
    checkOutput("postRstAccepted", dutAccepted, 2);
    checkOutput("postRstPulses", dutPulses[0], 2);

    $display("[TB] invalid phase tuples in Idle");
    clearLogs();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h700, 1'b1);
    repeat (3) tick();
    checkOutput("badAccessReady", PathAddrReady, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h700, 1'b1);
    repeat (3) tick();
    checkOutput("badDirReady", PathAddrReady, 0);
    checkOutput("badPhaseCommands", dutAccepted, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rew_cmd_issuer.md
REW_CMD_ISSUER -- requirements
Module: rew_cmd_issuer

Interface
REQ-001 SHALL have parameter AW, default 30: DRAM command address width.
REQ-002 SHALL have parameter BStride, default 8: address increment between consecutive chunk commands.
REQ-003 SHALL have parameters RW_R_Chunk, RW_W_Chunk, RO_R_Chunk, RO_W_Chunk, default 0 each: commands per phase. RO_W_Chunk may be 0; the others SHALL be >= 1.
REQ-004 SHALL have ports Clock (in, 1, sole clock) and Reset_n (in, 1, asynchronous active-low reset).
REQ-005 SHALL have ports RWAccess, ROAccess, Read, Writeback (in, 1 each): current REW phase from the status counter.
REQ-006 SHALL have ports PathAddr (in, AW, path base address), PathAddrValid (in, 1) and PathAddrReady (out, 1).
REQ-007 SHALL have ports RW_R_Transfer, RW_W_Transfer, RO_R_Transfer, RO_W_Transfer (out, 1 each): per-chunk pulses to the status counter.
REQ-008 SHALL have ports DRAMCommandAddress (out, AW), DRAMCommand (out, 3: 3'b001 read, 3'b000 write), DRAMCommandValid (out, 1) and DRAMCommandReady (in, 1).

Function
REQ-009 SHALL implement states Idle, Issue and Drain.
REQ-010 Phase valid SHALL be defined as exactly one of RWAccess/ROAccess high and exactly one of Read/Writeback high.
REQ-011 PathAddrReady SHALL be 1 only in Idle with phase valid; otherwise it SHALL be 0.
REQ-012 On PathAddrValid && PathAddrReady, the block SHALL latch PathAddr and the phase tuple, clear Idx, and load Limit = chunk count of that phase.
REQ-013 After the REQ-012 handshake, the block SHALL enter Issue if Limit > 0, else Drain (no commands issued).
REQ-014 In Issue: DRAMCommandValid = 1; DRAMCommandAddress = (latched base + Idx*BStride) mod 2^AW; DRAMCommand = read for Read phases, write for Writeback phases.
REQ-015 The command outputs SHALL be registered and SHALL stay stable while Valid && !Ready.
REQ-016 On DRAMCommandValid && DRAMCommandReady, the block SHALL pulse, for exactly that cycle, the Transfer output matching the latched phase, and increment Idx.
REQ-017 If Idx == Limit-1 at acceptance, the block SHALL move to Drain and drop Valid the next cycle; commands SHALL be back-to-back at full rate when Ready is held high.
REQ-018 In Drain, the block SHALL return to Idle when the current phase tuple differs from the latched tuple, or when Reset_n is deasserted-and-reasserted per REQ-022.
REQ-019 Changes of the phase inputs during Issue SHALL be ignored; the latched phase SHALL govern until Drain.
REQ-020 Each Transfer output SHALL be 0 except as set by REQ-016, and at most one Transfer output SHALL be high in any cycle.
REQ-021 Idx SHALL be log2(max chunk + 1) bits wide; the address multiply-add SHALL truncate to AW bits.

Reset
REQ-022 Reset_n low SHALL asynchronously force Idle, Idx = 0, DRAMCommandValid = 0, PathAddrReady = 0, all Transfer outputs = 0, DRAMCommandAddress = 0 and DRAMCommand = 3'b001, including mid-Issue; no partial command SHALL be issued after reset.
REQ-023 After release, the first handshake SHALL occur no earlier than the first rising edge with Reset_n high.

Verification (AW=32, BStride=8, chunks 4/4/3/0)
REQ-024 RW Read phase, PathAddr=0x100, Ready held 1 -> 4 read commands at 0x100, 0x108, 0x110, 0x118 in consecutive cycles, with 4 RW_R_Transfer pulses.
REQ-025 RO Read phase, Ready toggling 1,0,1,0... -> 3 commands, each held stable while stalled, with exactly 3 RO_R_Transfer pulses.
REQ-026 RO Writeback phase -> handshake accepted, zero commands issued, zero pulses, then Drain until the phase changes, then Idle.
REQ-027 PathAddr=0xFFFFFFF8, RW Write phase -> addresses 0xFFFFFFF8, 0x0, 0x8, 0x10, all writes.
REQ-028 Reset_n pulled low after 2 of 4 accepted commands -> Valid=0 and all outputs at reset values immediately; after release, PathAddrReady=1 again with phase valid.
REQ-029 Phase inputs driven invalid (RWAccess=ROAccess=1) in Idle -> PathAddrReady=0 and no commands issued.
